// File: rtl/bp_ckpt_queue_pkg.sv
// Shared widths and checkpoint entry layout for the branch-prediction checkpoint queue.
package bp_ckpt_queue_pkg;
  localparam int GSHARE_GHSR_WIDTH = 8;
  localparam int BP_CKPT_DEPTH     = 8;

  typedef struct packed {
    logic [31:0]                  pc;
    logic [GSHARE_GHSR_WIDTH-1:0] ghsr;
    logic                         predict_taken;
  } bp_ckpt_entry_t;
endpackage

// File: rtl/bp_ckpt_queue.sv
// In-order queue of predicted-branch checkpoints: up to two pushes per cycle from
// fetch, one pop per cycle at resolve, flush clears everything.
module bp_ckpt_queue
  import bp_ckpt_queue_pkg::*;
#(
  parameter int DEPTH = BP_CKPT_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          IF_push0_valid,
  input  logic                          IF_push1_valid,
  input  logic [31:0]                   IF_instr0_pc,
  input  logic [31:0]                   IF_instr1_pc,
  input  logic                          IF_instr0_predict_taken,
  input  logic                          IF_instr1_predict_taken,
  input  logic [GSHARE_GHSR_WIDTH-1:0]  IF_instr0_GHSR,
  input  logic [GSHARE_GHSR_WIDTH-1:0]  IF_instr1_GHSR,
  output logic                          ckpt_stall,
  input  logic                          EXE_resolve_valid,
  input  logic                          EXE_branch_taken,
  input  logic                          flush_valid,
  output logic                          head_valid,
  output logic [31:0]                   head_pc,
  output logic [GSHARE_GHSR_WIDTH-1:0]  head_GHSR,
  output logic                          head_predict_taken,
  output logic                          ckpt_mispredict,
  output logic [$clog2(DEPTH):0]        count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  bp_ckpt_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0]     r_head, r_tail;
  logic [CNT_W-1:0]     r_count;

  logic                 w_push_ok, w_wr0, w_wr1, w_pop;
  logic [CNT_W-1:0]     w_npush;
  logic [PTR_W-1:0]     w_tail_p1;
  bp_ckpt_entry_t       w_ent0, w_ent1, w_head_ent;

  // Stall depends only on registered occupancy so fetch sees it early in the cycle.
  assign ckpt_stall = (r_count > CNT_W'(DEPTH-2));
  assign head_valid = (r_count != '0);
  assign count      = r_count;

  assign w_push_ok = ~ckpt_stall & ~flush_valid & ~reset;
  assign w_wr0     = w_push_ok & (IF_push0_valid | IF_push1_valid);
  assign w_wr1     = w_push_ok & IF_push0_valid & IF_push1_valid;
  assign w_npush   = CNT_W'(w_wr0) + CNT_W'(w_wr1);
  assign w_pop     = EXE_resolve_valid & head_valid;
  assign w_tail_p1 = r_tail + PTR_W'(1);

  // A lone slot-1 branch still lands at tail so the queue stays dense.
  assign w_ent0 = IF_push0_valid ?
                  '{pc: IF_instr0_pc, ghsr: IF_instr0_GHSR, predict_taken: IF_instr0_predict_taken} :
                  '{pc: IF_instr1_pc, ghsr: IF_instr1_GHSR, predict_taken: IF_instr1_predict_taken};
  assign w_ent1 = '{pc: IF_instr1_pc, ghsr: IF_instr1_GHSR, predict_taken: IF_instr1_predict_taken};

  always_ff @(posedge clk) begin
    if (reset || flush_valid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop);
      r_tail  <= r_tail + PTR_W'(w_npush);
      r_count <= r_count + w_npush - CNT_W'(w_pop);
    end
  end

  // Storage carries no reset; head fields are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_wr0) r_mem[r_tail]    <= w_ent0;
    if (w_wr1) r_mem[w_tail_p1] <= w_ent1;
  end

  assign w_head_ent         = r_mem[r_head];
  assign head_pc            = head_valid ? w_head_ent.pc            : '0;
  assign head_GHSR          = head_valid ? w_head_ent.ghsr          : '0;
  assign head_predict_taken = head_valid ? w_head_ent.predict_taken : 1'b0;
  assign ckpt_mispredict    = w_pop & (head_predict_taken != EXE_branch_taken);
endmodule

// File: tb/tb_bp_ckpt_queue.sv
// Scoreboard bench for bp_ckpt_queue: accepted pushes enter a queue, resolves pop and compare.
module tb_bp_ckpt_queue;
  import bp_ckpt_queue_pkg::*;
  localparam int D  = 8;
  localparam int GW = GSHARE_GHSR_WIDTH;

  logic clk, rst, p0v, p1v, t0, t1, res, btaken, flush;
  logic [31:0] pc0, pc1;
  logic [GW-1:0] g0, g1;
  logic stall, hv, htaken, mispred;
  logic [31:0] hpc;
  logic [GW-1:0] hghsr;
  logic [$clog2(D):0] cnt;

  int total = 0;
  int bad   = 0;
  bp_ckpt_entry_t sb[$];
  bp_ckpt_entry_t exp_e;

  bp_ckpt_queue #(.DEPTH(D)) dut (
    .clk(clk), .reset(rst),
    .IF_push0_valid(p0v), .IF_push1_valid(p1v),
    .IF_instr0_pc(pc0), .IF_instr1_pc(pc1),
    .IF_instr0_predict_taken(t0), .IF_instr1_predict_taken(t1),
    .IF_instr0_GHSR(g0), .IF_instr1_GHSR(g1),
    .ckpt_stall(stall),
    .EXE_resolve_valid(res), .EXE_branch_taken(btaken), .flush_valid(flush),
    .head_valid(hv), .head_pc(hpc), .head_GHSR(hghsr), .head_predict_taken(htaken),
    .ckpt_mispredict(mispred), .count(cnt)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 0; p0v = 0; p1v = 0; t0 = 0; t1 = 0; res = 0; btaken = 0; flush = 0;
    pc0 = '0; pc1 = '0; g0 = '0; g1 = '0;
  endtask

  task automatic set_push(input bit v0, input logic [31:0] a0, input logic [GW-1:0] h0, input bit k0,
                          input bit v1, input logic [31:0] a1, input logic [GW-1:0] h1, input bit k1);
    p0v = v0; pc0 = a0; g0 = h0; t0 = k0;
    p1v = v1; pc1 = a1; g1 = h1; t1 = k1;
  endtask

  task automatic rand_dual();
    set_push(1, $urandom, GW'($urandom), 1'($urandom), 1, $urandom, GW'($urandom), 1'($urandom));
  endtask

  // Advance one cycle: update the reference model from the driven inputs, then clear inputs.
  task automatic tick();
    bit pop, st;
    if (rst || flush) sb.delete();
    else begin
      pop = res && (sb.size() != 0);
      st  = sb.size() > D-2;
      if (pop) void'(sb.pop_front());
      if (!st) begin
        if (p0v) sb.push_back('{pc: pc0, ghsr: g0, predict_taken: t0});
        if (p1v) sb.push_back('{pc: pc1, ghsr: g1, predict_taken: t1});
      end
    end
    @(posedge clk); #1;
    idle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; flush = 1; res = 1; set_push(1, 32'h55, 8'h1, 1, 1, 32'h66, 8'h2, 0);
    tick();
    res = 1; btaken = 1; #1;
    total++; if (cnt !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", cnt); end
    total++; if (hv !== 1'b0) begin bad++; $display("FAIL reset_head_valid got=%b exp=0", hv); end
    total++; if (hpc !== '0 || hghsr !== '0 || htaken !== 1'b0)
      begin bad++; $display("FAIL reset_head_fields got=%h/%h/%b exp=0", hpc, hghsr, htaken); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    total++; if (mispred !== 1'b0) begin bad++; $display("FAIL reset_mispredict_empty got=%b exp=0", mispred); end
    tick();
    total++; if (cnt !== '0) begin bad++; $display("FAIL resolve_empty_count got=%0d exp=0", cnt); end
  endtask

  task automatic test_single_push();
    set_push(1, 32'h100, 8'h05, 1, 0, 0, 0, 0); tick();
    total++; if (hv !== 1'b1 || hpc !== 32'h100 || hghsr !== 8'h05 || htaken !== 1'b1 || cnt !== 1)
      begin bad++; $display("FAIL single_push got=%b/%h/%h/%b/%0d exp=1/100/05/1/1", hv, hpc, hghsr, htaken, cnt); end
    set_push(0, 0, 0, 0, 1, 32'h180, 8'h0A, 0); tick();
    total++; if (cnt !== 2 || hpc !== 32'h100)
      begin bad++; $display("FAIL slot1_push got=%0d/%h exp=2/100", cnt, hpc); end
    for (int i = 0; i < 2; i++) begin
      res = 1; btaken = 1; #1;
      exp_e = sb[0];
      total++; if (hpc !== exp_e.pc || hghsr !== exp_e.ghsr)
        begin bad++; $display("FAIL single_pop_head got=%h/%h exp=%h/%h", hpc, hghsr, exp_e.pc, exp_e.ghsr); end
      total++; if (mispred !== (exp_e.predict_taken != 1'b1))
        begin bad++; $display("FAIL single_pop_mispredict got=%b exp=%b", mispred, exp_e.predict_taken != 1'b1); end
      tick();
    end
    total++; if (cnt !== '0) begin bad++; $display("FAIL single_drain_count got=%0d exp=0", cnt); end
  endtask

  task automatic test_dual_resolve();
    set_push(1, 32'h200, 8'h11, 0, 1, 32'h204, 8'h22, 1); tick();
    total++; if (cnt !== 2) begin bad++; $display("FAIL dual_count got=%0d exp=2", cnt); end
    res = 1; btaken = 1; #1;
    total++; if (hpc !== 32'h200 || mispred !== 1'b1)
      begin bad++; $display("FAIL dual_pop0 got=%h/%b exp=200/1", hpc, mispred); end
    tick();
    res = 1; btaken = 1; #1;
    total++; if (hpc !== 32'h204 || mispred !== 1'b0)
      begin bad++; $display("FAIL dual_pop1 got=%h/%b exp=204/0", hpc, mispred); end
    tick();
    total++; if (cnt !== '0 || hv !== 1'b0) begin bad++; $display("FAIL dual_drain got=%0d/%b exp=0/0", cnt, hv); end
  endtask

  task automatic drain(input string tag);
    while (sb.size() != 0) begin
      res = 1; btaken = 1'($urandom); #1;
      exp_e = sb[0];
      total++; if (hv !== 1'b1 || hpc !== exp_e.pc || hghsr !== exp_e.ghsr || htaken !== exp_e.predict_taken)
        begin bad++; $display("FAIL %s_pop got=%h/%h/%b exp=%h/%h/%b", tag, hpc, hghsr, htaken, exp_e.pc, exp_e.ghsr, exp_e.predict_taken); end
      total++; if (mispred !== (exp_e.predict_taken != btaken))
        begin bad++; $display("FAIL %s_mispredict got=%b exp=%b", tag, mispred, exp_e.predict_taken != btaken); end
      tick();
    end
    total++; if (cnt !== '0) begin bad++; $display("FAIL %s_drain_count got=%0d exp=0", tag, cnt); end
  endtask

  task automatic test_fill_stall();
    set_push(1, 32'h300, 8'h30, 1, 0, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin rand_dual(); tick(); end
    total++; if (cnt !== 7 || stall !== 1'b1) begin bad++; $display("FAIL fill7 got=%0d/%b exp=7/1", cnt, stall); end
    rand_dual(); tick();
    total++; if (cnt !== 7) begin bad++; $display("FAIL stalled_push_ignored got=%0d exp=7", cnt); end
    res = 1; tick();
    total++; if (cnt !== 6 || stall !== 1'b0) begin bad++; $display("FAIL pop_unstall got=%0d/%b exp=6/0", cnt, stall); end
    rand_dual(); tick();
    total++; if (cnt !== 8 || stall !== 1'b1) begin bad++; $display("FAIL fill8 got=%0d/%b exp=8/1", cnt, stall); end
    rand_dual(); tick();
    total++; if (cnt !== 8) begin bad++; $display("FAIL full_push_ignored got=%0d exp=8", cnt); end
    drain("fill");
  endtask

  task automatic test_simul_push_pop();
    rst = 1; tick();
    for (int i = 0; i < 3; i++) begin rand_dual(); tick(); end
    for (int i = 0; i < 3; i++) begin res = 1; tick(); end
    for (int i = 0; i < 2; i++) begin
      rand_dual(); res = 1; btaken = 1'($urandom); #1;
      exp_e = sb[0];
      total++; if (hpc !== exp_e.pc || mispred !== (exp_e.predict_taken != btaken))
        begin bad++; $display("FAIL simul_head got=%h/%b exp=%h/%b", hpc, mispred, exp_e.pc, exp_e.predict_taken != btaken); end
      tick();
      total++; if (cnt !== 4 + i || hpc !== sb[0].pc)
        begin bad++; $display("FAIL simul_count got=%0d/%h exp=%0d/%h", cnt, hpc, 4 + i, sb[0].pc); end
    end
    drain("wrap");
  endtask

  task automatic test_flush();
    rand_dual(); tick(); rand_dual(); tick();
    set_push(1, 32'h400, 8'h40, 0, 0, 0, 0, 0); tick();
    total++; if (cnt !== 5) begin bad++; $display("FAIL flush_setup got=%0d exp=5", cnt); end
    flush = 1; res = 1; rand_dual(); tick();
    total++; if (cnt !== '0 || hv !== 1'b0 || hpc !== '0 || hghsr !== '0 || htaken !== 1'b0)
      begin bad++; $display("FAIL flush_clear got=%0d/%b/%h/%h/%b exp=0", cnt, hv, hpc, hghsr, htaken); end
    set_push(1, 32'h500, 8'h50, 1, 0, 0, 0, 0); tick();
    total++; if (cnt !== 1 || hpc !== 32'h500) begin bad++; $display("FAIL post_flush_push got=%0d/%h exp=1/500", cnt, hpc); end
    drain("flush");
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin rand_dual(); tick(); end
    total++; if (cnt !== 6) begin bad++; $display("FAIL midreset_setup got=%0d exp=6", cnt); end
    rst = 1; rand_dual(); res = 1; tick();
    total++; if (cnt !== '0 || stall !== 1'b0 || hv !== 1'b0)
      begin bad++; $display("FAIL midreset got=%0d/%b/%b exp=0/0/0", cnt, stall, hv); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      p0v = 1'($urandom); p1v = 1'($urandom);
      pc0 = $urandom; pc1 = $urandom; g0 = GW'($urandom); g1 = GW'($urandom);
      t0 = 1'($urandom); t1 = 1'($urandom);
      res = ($urandom_range(0, 2) != 0); btaken = 1'($urandom);
      flush = ($urandom_range(0, 30) == 0); rst = ($urandom_range(0, 80) == 0);
      #1;
      total++; if (cnt !== ($clog2(D)+1)'(sb.size()) || stall !== (sb.size() > D-2) || hv !== (sb.size() != 0))
        begin bad++; $display("FAIL rand_state cyc=%0d got=%0d/%b/%b exp=%0d", i, cnt, stall, hv, sb.size()); end
      if (sb.size() != 0) begin
        exp_e = sb[0];
        total++; if (hpc !== exp_e.pc || hghsr !== exp_e.ghsr || htaken !== exp_e.predict_taken ||
                     mispred !== (res && exp_e.predict_taken != btaken))
          begin bad++; $display("FAIL rand_head cyc=%0d got=%h/%h/%b/%b exp=%h/%h/%b", i, hpc, hghsr, htaken, mispred, exp_e.pc, exp_e.ghsr, exp_e.predict_taken); end
      end else begin
        total++; if (hpc !== '0 || hghsr !== '0 || htaken !== 1'b0 || mispred !== 1'b0)
          begin bad++; $display("FAIL rand_empty cyc=%0d got=%h/%h/%b/%b exp=0", i, hpc, hghsr, htaken, mispred); end
      end
      tick();
    end
  endtask

  initial begin
    clk = 0;
    idle();
    test_reset();
    test_single_push();
    test_dual_resolve();
    test_fill_stall();
    test_simul_push_pop();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
